// File: rtl/fpmul_pkg.sv
// Shared definitions for the FPmul front-end arbiter.
//   WIDTH_DEF   : default operand/result width (IEEE-754 single)
//   LATENCY_DEF : default FPmul pipeline depth in cycles (legal 1..16)
//   req_id_t    : requester identifier, also the round-robin pointer type
//   tag_entry_t : one tag-pipe slot {valid, tag}
package fpmul_pkg;

  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned LATENCY_DEF = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t tag;
  } tag_entry_t;

endpackage

// File: rtl/fpmul_tag_pipe.sv
// LATENCY-deep shift register of {valid, tag} entries that tracks which
// requester owns the FPmul result emerging LATENCY cycles after issue.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every slot
//   d   : entry pushed this cycle
//   q   : entry pushed LATENCY cycles earlier
module fpmul_tag_pipe
  import fpmul_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  tag_entry_t d,
  output tag_entry_t q
);

  tag_entry_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[LATENCY-1];

endmodule

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared, fully pipelined FPmul.
// Grants one requester per cycle, drives the FPmul operands, and returns each
// result to its owner LATENCY+1 cycles after the grant.
//   clk, rst                  : clock, synchronous active-high reset
//   reqK_valid/a/b/ready      : requester K operand handshake (K = 0, 1)
//   mul_a, mul_b, mul_z       : operands to / result from the external FPmul
//   outK_valid, outK_data     : one-cycle result pulse and held result data
//   inflight                  : operations issued but not yet delivered
module fpmul_arbiter
  import fpmul_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_z,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  output logic [4:0]       inflight
);

  req_id_t    last_grant;
  logic       gnt0, gnt1;
  logic       issued, delivered;
  tag_entry_t push, pop;

  // Requester 0 wins unless requester 1 alone is valid or requester 0 was
  // the most recent winner; all grants are suppressed while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || last_grant == REQ1)) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (gnt0) begin
      mul_a = req0_a;
      mul_b = req0_b;
    end else if (gnt1) begin
      mul_a = req1_a;
      mul_b = req1_b;
    end
  end

  always_comb begin
    push       = '0;
    push.valid = gnt0 | gnt1;
    push.tag   = gnt1 ? REQ1 : REQ0;
  end

  fpmul_tag_pipe #(
    .LATENCY(LATENCY)
  ) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .d  (push),
    .q  (pop)
  );

  assign issued    = gnt0 | gnt1;
  assign delivered = out0_valid | out1_valid;

  // pop lines up with mul_z for the same operation; capture it here so the
  // result appears one cycle later with its valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ1;
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
      out0_data  <= '0;
      out1_data  <= '0;
      inflight   <= '0;
    end else begin
      if (gnt0) begin
        last_grant <= REQ0;
      end else if (gnt1) begin
        last_grant <= REQ1;
      end
      out0_valid <= pop.valid && (pop.tag == REQ0);
      out1_valid <= pop.valid && (pop.tag == REQ1);
      if (pop.valid && pop.tag == REQ0) begin
        out0_data <= mul_z;
      end
      if (pop.valid && pop.tag == REQ1) begin
        out1_data <= mul_z;
      end
      if (issued && !delivered) begin
        inflight <= inflight + 5'd1;
      end else if (!issued && delivered) begin
        inflight <= inflight - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter: a LATENCY=4 instance and a LATENCY=1
// instance, each paired with a behavioural FPmul of matching depth.
module tb_fpmul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // LATENCY = 4 instance
  logic        r0v, r0r, r1v, r1r, o0v, o1v;
  logic [31:0] r0a, r0b, r1a, r1b, ma, mb, mz, o0d, o1d;
  logic [4:0]  infl;

  // LATENCY = 1 instance
  logic        l0v, l0r, l1v, l1r, lo0v, lo1v;
  logic [31:0] l0a, l0b, l1a, l1b, lma, lmb, lmz, lo0d, lo1d;
  logic [4:0]  linfl;

  int checks = 0;
  int errors = 0;
  int peak   = 0;

  // Truncating single-precision multiply, exact for the normal operands used.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  logic [31:0] zp [4];
  always @(posedge clk) begin
    zp[0] <= fmul(ma, mb);
    for (int i = 1; i < 4; i++) zp[i] <= zp[i-1];
  end
  assign mz = zp[3];

  logic [31:0] lz;
  always @(posedge clk) lz <= fmul(lma, lmb);
  assign lmz = lz;

  fpmul_arbiter #(.WIDTH(32), .LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0r),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1r),
    .mul_a(ma), .mul_b(mb), .mul_z(mz),
    .out0_valid(o0v), .out0_data(o0d), .out1_valid(o1v), .out1_data(o1d),
    .inflight(infl)
  );

  fpmul_arbiter #(.WIDTH(32), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req0_valid(l0v), .req0_a(l0a), .req0_b(l0b), .req0_ready(l0r),
    .req1_valid(l1v), .req1_a(l1a), .req1_b(l1b), .req1_ready(l1r),
    .mul_a(lma), .mul_b(lmb), .mul_z(lmz),
    .out0_valid(lo0v), .out0_data(lo0d), .out1_valid(lo1v), .out1_data(lo1d),
    .inflight(linfl)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int exp_inf, g, d;
    logic e0, e1;

    rst = 1'b1;
    r0v = 0; r1v = 0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    l0v = 0; l1v = 0; l0a = '0; l0b = '0; l1a = '0; l1b = '0;
    tick(); tick();

    // Ready and operand mux stay quiet while reset is asserted
    r0v = 1; r1v = 1; l0v = 1; r0a = 32'h3F800000; r0b = 32'h3F800000;
    settle();
    chk("rst_ready0", 32'(r0r), 32'd0);
    chk("rst_ready1", 32'(r1r), 32'd0);
    chk("rst_l1_ready0", 32'(l0r), 32'd0);
    chk("rst_mul_a", ma, 32'd0);
    r0v = 0; r1v = 0; l0v = 0;
    tick();
    rst = 1'b0;
    settle();
    chk("reset_out0_valid", 32'(o0v), 32'd0);
    chk("reset_out1_valid", 32'(o1v), 32'd0);
    chk("reset_out0_data", o0d, 32'd0);
    chk("reset_out1_data", o1d, 32'd0);
    chk("reset_inflight", 32'(infl), 32'd0);

    // Idle
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk("idle_mul_a", ma, 32'd0);
      chk("idle_mul_b", mb, 32'd0);
      chk("idle_outs", {30'd0, o1v, o0v}, 32'd0);
      chk("idle_inflight", 32'(infl), 32'd0);
    end

    // Single op: 1.0 x 2.0 on requester 0, result 5 cycles after grant
    tick();
    r0v = 1; r0a = 32'h3F800000; r0b = 32'h40000000;
    settle();
    chk("single_ready0", 32'(r0r), 32'd1);
    chk("single_ready1", 32'(r1r), 32'd0);
    chk("single_mul_a", ma, 32'h3F800000);
    chk("single_mul_b", mb, 32'h40000000);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) r0v = 0;
      settle();
      chk("single_out0_valid", 32'(o0v), 32'(k == 5));
      chk("single_out1_valid", 32'(o1v), 32'd0);
      chk("single_inflight", 32'(infl), (k <= 5) ? 32'd1 : 32'd0);
      if (k >= 5) chk("single_out0_data", o0d, 32'h40000000);
    end

    // Contention from reset: grants 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("reset2_out0_data", o0d, 32'd0);
    tick();
    r0a = 32'h40000000; r0b = 32'h40400000;   // 2.0 x 3.0 = 6.0
    r1a = 32'h40800000; r1b = 32'h3F000000;   // 4.0 x 0.5 = 2.0
    for (int k = 0; k < 10; k++) begin
      r0v = (k < 4); r1v = (k < 4);
      settle();
      chk("cont_ready0", 32'(r0r), 32'(k < 4 && (k % 2) == 0));
      chk("cont_ready1", 32'(r1r), 32'(k < 4 && (k % 2) == 1));
      if (k < 4) chk("cont_mul_a", ma, ((k % 2) == 0) ? 32'h40000000 : 32'h40800000);
      e0 = (k == 5 || k == 7);
      e1 = (k == 6 || k == 8);
      chk("cont_out0_valid", 32'(o0v), 32'(e0));
      chk("cont_out1_valid", 32'(o1v), 32'(e1));
      if (e0) chk("cont_out0_data", o0d, 32'h40C00000);
      if (e1) chk("cont_out1_data", o1d, 32'h40000000);
      g = (k < 4) ? k : 4;
      d = (k <= 5) ? 0 : ((k - 5 > 4) ? 4 : k - 5);
      chk("cont_inflight", 32'(infl), 32'(g - d));
      tick();
    end

    // Streaming: requester 1 for 20 cycles, alternating 1.5x2.0 and 1.5x4.0
    r0v = 0;
    for (int k = 0; k < 26; k++) begin
      r1v = (k < 20);
      r1a = 32'h3FC00000;
      r1b = ((k % 2) == 0) ? 32'h40000000 : 32'h40800000;
      settle();
      chk("stream_ready1", 32'(r1r), 32'(k < 20));
      chk("stream_ready0", 32'(r0r), 32'd0);
      chk("stream_out1_valid", 32'(o1v), 32'(k >= 5 && k < 25));
      chk("stream_out0_valid", 32'(o0v), 32'd0);
      if (k >= 5 && k < 25)
        chk("stream_out1_data", o1d, (((k - 5) % 2) == 0) ? 32'h40400000 : 32'h40C00000);
      g = (k < 20) ? k : 20;
      d = (k <= 5) ? 0 : ((k - 5 > 20) ? 20 : k - 5);
      exp_inf = g - d;
      chk("stream_inflight", 32'(infl), 32'(exp_inf));
      if (int'(infl) > peak) peak = int'(infl);
      tick();
    end
    chk("stream_peak", 32'(peak), 32'd5);
    r1v = 0;

    // Mid-op reset: three ops, reset two cycles after the last
    r0a = 32'h40000000; r0b = 32'h40400000;
    for (int k = 0; k < 3; k++) begin
      r0v = 1;
      settle();
      chk("midrst_ready0", 32'(r0r), 32'd1);
      tick();
    end
    r0v = 0;
    settle();
    chk("midrst_inflight3", 32'(infl), 32'd3);
    tick();
    rst = 1'b1; r0v = 1; r1v = 1;
    settle();
    chk("midrst_ready0_rst", 32'(r0r), 32'd0);
    chk("midrst_ready1_rst", 32'(r1r), 32'd0);
    tick();
    rst = 1'b0; r0v = 0; r1v = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("midrst_outs", {30'd0, o1v, o0v}, 32'd0);
      chk("midrst_inflight", 32'(infl), 32'd0);
      tick();
    end
    r0v = 1; r1v = 1;
    settle();
    chk("midrst_next_ready0", 32'(r0r), 32'd1);
    chk("midrst_next_ready1", 32'(r1r), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin r0v = 0; r1v = 0; end
      settle();
      chk("midrst_drain_out0_valid", 32'(o0v), 32'(k == 5));
      if (k == 5) chk("midrst_drain_out0_data", o0d, 32'h40C00000);
    end

    // LATENCY=1 instance: 3.0 x 3.0 on requester 1, result 2 cycles after grant
    tick();
    l1v = 1; l1a = 32'h40400000; l1b = 32'h40400000;
    settle();
    chk("l1_ready1", 32'(l1r), 32'd1);
    chk("l1_mul_a", lma, 32'h40400000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) l1v = 0;
      settle();
      chk("l1_out1_valid", 32'(lo1v), 32'(k == 2));
      chk("l1_out0_valid", 32'(lo0v), 32'd0);
      chk("l1_inflight", 32'(linfl), (k <= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("l1_out1_data", lo1d, 32'h41100000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
